// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Command FIFO feeding an external combinational ALU; one result at
//            a time is presented on a valid/ready response port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [2:0]               cmd_op_i,
    input  logic [7:0]               cmd_a_i,
    input  logic [7:0]               cmd_b_i,
    output logic [7:0]               alu_a_o,
    output logic [7:0]               alu_b_o,
    output logic [2:0]               alu_op_o,
    input  logic [7:0]               alu_res_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [7:0]               rsp_data_o,
    output logic                     rsp_zero_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

    localparam int                 c_PTR_W  = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL   = DEPTH[c_PTR_W:0];
    localparam logic [2:0]         c_OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [18:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_cnt;

    logic [7:0]           r_alu_a;
    logic [7:0]           r_alu_b;
    logic [2:0]           r_alu_op;
    logic                 r_rsp_valid;
    logic [7:0]           r_rsp_data;

    logic                 w_not_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_rsp_clear;
    logic [18:0]          w_head;
    logic [7:0]           w_result;

    // Readiness comes from the registered count only, so a pop on the same
    // edge never frees a slot for a push.
    assign w_not_full = (r_cnt < c_FULL);
    assign w_push     = cmd_valid_i & w_not_full;
    assign w_head     = r_mem[r_rptr];

    // Equality is resolved locally; the ALU result is ignored for that op.
    assign w_result   = (r_alu_op == c_OP_EQ) ? {7'd0, (r_alu_a == r_alu_b)}
                                              : alu_res_i;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_rsp_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cnt != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready_i) begin
                    w_rsp_clear = 1'b1;
                    if (r_cnt != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_op_i, cmd_a_i, cmd_b_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_alu_op    <= 3'b000;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            if (w_pop) begin
                {r_alu_op, r_alu_a, r_alu_b} <= w_head;
            end
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_result;
            end else if (w_rsp_clear) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = w_not_full;
    assign alu_a_o     = r_alu_a;
    assign alu_b_o     = r_alu_b;
    assign alu_op_o    = r_alu_op;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_zero_o  = (r_rsp_data == 8'h00);
    assign fifo_cnt_o  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Directed bench for alu_seq_ctrl with a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic [2:0] fifo_cnt;

    logic       ready_fixed;
    logic       rand_mode;
    logic       rand_bit;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t       m_q[$];
    cmd_t       m_alu;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_busy;      // 0 nothing issued, 1 operands on ALU, 2 result presented

    logic [7:0] got_data[$];
    logic       got_zero[$];

    alu_seq_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_a_i     (cmd_a),
        .cmd_b_i     (cmd_b),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_res_i   (alu_res),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_zero_o  (rsp_zero),
        .fifo_cnt_o  (fifo_cnt)
    );

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a << b[2:0];
            3'b011:  return a >> b[2:0];
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    // External ALU; it deliberately answers 00 for the equal op.
    assign alu_res   = (alu_op == 3'b111) ? 8'h00 : alu_fn(alu_op, alu_a, alu_b);
    assign rsp_ready = rand_mode ? rand_bit : ready_fixed;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_alu   = '0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_busy  = 0;
    endtask

    task automatic model_step(input logic s_valid, input cmd_t s_cmd, input logic s_ready);
        logic take;
        take = s_valid && (m_q.size() < DEPTH);
        if (m_busy == 0) begin
            if (m_q.size() > 0) begin
                m_alu  = m_q.pop_front();
                m_busy = 1;
            end
        end else if (m_busy == 1) begin
            m_data  = alu_fn(m_alu.op, m_alu.a, m_alu.b);
            m_valid = 1'b1;
            m_busy  = 2;
        end else if (m_valid && s_ready) begin
            m_valid = 1'b0;
            if (m_q.size() > 0) begin
                m_alu  = m_q.pop_front();
                m_busy = 1;
            end else begin
                m_busy = 0;
            end
        end
        if (take) m_q.push_back(s_cmd);
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        logic s_valid;
        logic s_ready;
        cmd_t s_cmd;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check("rsp_valid", rsp_valid, m_valid);
            check("rsp_data",  rsp_data,  m_data);
            check("rsp_zero",  rsp_zero,  (m_data == 8'h00));
            check("cmd_ready", cmd_ready, (m_q.size() < DEPTH));
            check("fifo_cnt",  fifo_cnt,  m_q.size());
            check("alu_a",     alu_a,     m_alu.a);
            check("alu_b",     alu_b,     m_alu.b);
            check("alu_op",    alu_op,    m_alu.op);
            s_valid = cmd_valid;
            s_cmd   = {cmd_op, cmd_a, cmd_b};
            s_ready = rsp_ready;
            if (rst_n && rsp_valid && rsp_ready) begin
                got_data.push_back(rsp_data);
                got_zero.push_back(rsp_zero);
            end
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step(s_valid, s_cmd, s_ready);
        end
    end

    initial begin
        rand_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rand_bit = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_try(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int max_cycles, output logic acc);
        logic r;
        acc       = 1'b0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic acc;
        push_try(op, a, b, 200, acc);
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic wait_results(input int target, input int budget);
        for (int i = 0; i < budget && got_data.size() < target; i++) begin
            @(posedge clk);
            #1;
        end
        check("result_count", (got_data.size() >= target), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n_valid;
        logic acc;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 3'b000;
        cmd_a       = 8'h00;
        cmd_b       = 8'h00;
        ready_fixed = 1'b0;
        rand_mode   = 1'b0;
        #2;
        check("rst_valid", rsp_valid, 0);
        check("rst_zero",  rsp_zero,  1);
        check("rst_ready", cmd_ready, 1);
        check("rst_cnt",   fifo_cnt,  0);
        check("rst_data",  rsp_data,  0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single add: latency of two edges after acceptance
        ready_fixed = 1'b1;
        push(3'b000, 8'h0F, 8'h01);
        @(negedge clk);
        check("lat_k_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check("lat_k1_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check("lat_k2_valid", rsp_valid, 1);
        check("lat_k2_data",  rsp_data,  8'h10);
        check("lat_k2_zero",  rsp_zero,  0);
        wait_results(1, 50);
        idle(3);

        // Equal op ignores the ALU result
        base = got_data.size();
        push(3'b111, 8'h5A, 8'h5A);
        push(3'b111, 8'h5A, 8'h5B);
        wait_results(base + 2, 100);
        check("eq_res0",  got_data[base],     8'h01);
        check("eq_zero0", got_zero[base],     0);
        check("eq_res1",  got_data[base + 1], 8'h00);
        check("eq_zero1", got_zero[base + 1], 1);
        idle(3);

        // Full FIFO under backpressure
        ready_fixed = 1'b0;
        base = got_data.size();
        push(3'b000, 8'h10, 8'h20);
        push(3'b001, 8'h32, 8'h08);
        push(3'b010, 8'h03, 8'h02);
        push(3'b011, 8'h80, 8'h03);
        push(3'b100, 8'hF0, 8'h3C);
        push_try(3'b110, 8'h01, 8'h01, 3, acc);
        check("full_reject", acc, 0);
        check("full_cnt",    fifo_cnt,  4);
        check("full_ready",  cmd_ready, 0);
        check("full_valid",  rsp_valid, 1);
        ready_fixed = 1'b1;
        wait_results(base + 5, 100);
        check("full_res0", got_data[base],     8'h30);
        check("full_res1", got_data[base + 1], 8'h2A);
        check("full_res2", got_data[base + 2], 8'h0C);
        check("full_res3", got_data[base + 3], 8'h10);
        check("full_res4", got_data[base + 4], 8'h30);
        check("full_total", got_data.size(), base + 5);
        idle(3);

        // Simultaneous push and pop at count 2
        ready_fixed = 1'b0;
        base = got_data.size();
        push(3'b101, 8'h0F, 8'h30);
        push(3'b110, 8'h0F, 8'hFF);
        push(3'b000, 8'hFF, 8'h01);
        check("pp_cnt_before", fifo_cnt, 2);
        ready_fixed = 1'b1;
        push(3'b001, 8'h05, 8'h06);
        check("pp_cnt_after", fifo_cnt, 2);
        wait_results(base + 4, 100);
        check("pp_res0", got_data[base],     8'h3F);
        check("pp_res1", got_data[base + 1], 8'hF0);
        check("pp_res2", got_data[base + 2], 8'h00);
        check("pp_res3", got_data[base + 3], 8'hFF);
        idle(3);

        // Pointer wrap with random consumer stalls
        rand_mode = 1'b1;
        base = got_data.size();
        for (int i = 1; i <= 10; i++) push(3'b001, 8'(i), 8'h01);
        wait_results(base + 10, 500);
        rand_mode   = 1'b0;
        ready_fixed = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("wrap_res",  got_data[base + i], 8'(i));
            check("wrap_zero", got_zero[base + i], (i == 0));
        end
        idle(3);

        // Reset while operands are on the ALU
        ready_fixed = 1'b0;
        base = got_data.size();
        push(3'b000, 8'h11, 8'h22);
        push(3'b001, 8'h40, 8'h01);
        push(3'b110, 8'hAA, 8'h55);
        push(3'b101, 8'h0C, 8'h03);
        check("mr_cnt", fifo_cnt, 3);
        ready_fixed = 1'b1;
        @(posedge clk); #1;
        check("mr_drive_a", alu_a, 8'h40);
        check("mr_drive_valid", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        check("mr_valid", rsp_valid, 0);
        check("mr_data",  rsp_data,  0);
        check("mr_zero",  rsp_zero,  1);
        check("mr_ready", cmd_ready, 1);
        check("mr_cnt0",  fifo_cnt,  0);
        check("mr_alu_a", alu_a,     0);
        check("mr_alu_b", alu_b,     0);
        check("mr_alu_op", alu_op,   0);
        idle(2);
        rst_n = 1'b1;
        n_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) n_valid++;
        end
        check("mr_no_rsp", n_valid, 0);
        check("mr_res0",   got_data[base], 8'h33);
        check("mr_total",  got_data.size(), base + 1);
        @(posedge clk); #1;
        push(3'b000, 8'h01, 8'h01);
        wait_results(base + 2, 50);
        check("mr_new_res", got_data[base + 1], 8'h02);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
